load_store_unit: RTL and testbench

Parametrised memory-access engine for the multicycle core. It replaces the fixed single-cycle memory read/write path and the combinational load formatter with a handshaked unit that tolerates wait states, generates byte enables and aligned write data, and sign/zero-extends load results. It sits between the control FSM and the memory bus. The FSM issues one request, then stalls on `lsu_busy` until `lsu_done` pulses.

---
 rtl/load_store_unit.sv | 209 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - handshaked load/store engine between the control FSM and the memory bus
// Generates aligned address, byte enables and lane-shifted store data; extends load results.
module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lsu_req,
    input  logic                lsu_we,
    input  logic [2:0]          lsu_funct3,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [XLEN-1:0]     lsu_wdata,
    output logic                lsu_busy,
    output logic                lsu_done,
    output logic [XLEN-1:0]     lsu_rdata,
    output logic                lsu_err,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [XLEN/8-1:0]   bus_be,
    output logic [XLEN-1:0]     bus_wdata,
    input  logic                bus_rvalid,
    input  logic [XLEN-1:0]     bus_rdata,
    input  logic                bus_err
);

    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [OFF_W-1:0]  off_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BE_W-1:0]   be_q;
    logic [XLEN-1:0]   wdata_q;
    logic              err_q;
    logic [XLEN-1:0]   rdata_q;
    logic [CNT_W-1:0]  cnt;

    logic [OFF_W-1:0]  off_in;
    logic              bad_in;
    logic              misaligned;
    logic              illegal;
    logic [BE_W-1:0]   be_base;
    logic [BE_W-1:0]   be_in;
    logic [XLEN-1:0]   wmask;
    logic [XLEN-1:0]   wdata_in;
    logic [ADDR_W-1:0] addr_in;

    logic [XLEN-1:0]   lane;
    logic [XLEN-1:0]   size_mask;
    logic              sign_bit;
    logic [XLEN-1:0]   load_ext;

    logic              accept;
    logic              timeout_hit;

    // Request decode, evaluated on the raw inputs so it can be latched in the accept cycle.
    always_comb begin
        off_in  = lsu_addr[OFF_W-1:0];
        addr_in = {lsu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

        if (lsu_we) begin
            illegal = lsu_funct3[2] || (XLEN == 32 && lsu_funct3[1:0] == 2'd3);
        end else begin
            illegal = (lsu_funct3 == 3'b111) ||
                      (XLEN == 32 && (lsu_funct3 == 3'b011 || lsu_funct3 == 3'b110));
        end

        case (lsu_funct3[1:0])
            2'd1:    misaligned = off_in[0];
            2'd2:    misaligned = (off_in[1:0] != 2'd0);
            2'd3:    misaligned = (off_in != '0);
            default: misaligned = 1'b0;
        endcase
        bad_in = illegal || misaligned;

        case (lsu_funct3[1:0])
            2'd0:    be_base = BE_W'(1);
            2'd1:    be_base = BE_W'(3);
            2'd2:    be_base = BE_W'(15);
            default: be_base = '1;
        endcase
        be_in = be_base << off_in;

        wmask = '0;
        for (int i = 0; i < BE_W; i++) begin
            wmask[8*i +: 8] = {8{be_in[i]}};
        end
        wdata_in = (lsu_wdata << {off_in, 3'b000}) & wmask;
    end

    // Load formatter: shift the addressed lane down, then sign- or zero-extend.
    always_comb begin
        lane = bus_rdata >> {off_q, 3'b000};
        case (f3_q[1:0])
            2'd0: begin
                size_mask = XLEN'(8'hFF);
                sign_bit  = lane[7];
            end
            2'd1: begin
                size_mask = XLEN'(16'hFFFF);
                sign_bit  = lane[15];
            end
            2'd2: begin
                size_mask = XLEN'(32'hFFFF_FFFF);
                sign_bit  = lane[31];
            end
            default: begin
                size_mask = '1;
                sign_bit  = lane[XLEN-1];
            end
        endcase
        load_ext = lane & size_mask;
        if (!f3_q[2] && sign_bit) begin
            load_ext = load_ext | ~size_mask;
        end
    end

    assign accept      = lsu_req && (state == S_IDLE || state == S_DONE);
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        we_q    <= lsu_we;
                        f3_q    <= lsu_funct3;
                        off_q   <= off_in;
                        addr_q  <= addr_in;
                        be_q    <= be_in;
                        wdata_q <= wdata_in;
                        err_q   <= bad_in;
                        cnt     <= '0;
                        state   <= bad_in ? S_DONE : S_REQ;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    // A handshake in the final allowed cycle wins over the timeout.
                    if (bus_ready) begin
                        if (we_q) begin
                            err_q <= bus_err;
                            state <= S_DONE;
                        end else begin
                            state <= S_RESP;
                        end
                        cnt <= cnt + CNT_W'(1);
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus_rvalid) begin
                        err_q <= bus_err;
                        if (!bus_err) begin
                            rdata_q <= load_ext;
                        end
                        state <= S_DONE;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign lsu_busy  = (state == S_REQ) || (state == S_RESP);
    assign lsu_done  = (state == S_DONE);
    assign lsu_err   = (state == S_DONE) && err_q;
    assign lsu_rdata = rdata_q;

    assign bus_valid = (state == S_REQ);
    assign bus_we    = bus_valid && we_q;
    assign bus_addr  = bus_valid ? addr_q  : '0;
    assign bus_be    = bus_valid ? be_q    : '0;
    assign bus_wdata = bus_valid ? wdata_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - table-driven scoreboard bench for load_store_unit (XLEN 32 and 64)
module tb_load_store_unit;

    typedef struct {
        logic        sel;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          rdly;
        logic        berr;
        logic        bus;
        logic [7:0]  be;
        logic [63:0] bwdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        clk, reset, req, we, sel;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wdata, rdata;
    logic        ready, rvalid, berr;

    logic        busy32, done32, err32, valid32, we32;
    logic [31:0] rdata32, addr32, wdata32;
    logic [3:0]  be32;
    logic        busy64, done64, err64, valid64, we64;
    logic [63:0] rdata64, wdata64;
    logic [31:0] addr64;
    logic [7:0]  be64;

    logic        o_busy, o_done, o_err, o_valid, o_we;
    logic [63:0] o_rdata, o_wdata;
    logic [31:0] o_addr;
    logic [7:0]  o_be;

    int   errors = 0;
    int   checks = 0;
    exp_t sb [$];
    exp_t mon_e;
    vec_t tbl [$];
    vec_t hv;

    load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .reset(reset), .lsu_req(req && !sel), .lsu_we(we), .lsu_funct3(f3),
        .lsu_addr(addr), .lsu_wdata(wdata[31:0]), .lsu_busy(busy32), .lsu_done(done32),
        .lsu_rdata(rdata32), .lsu_err(err32), .bus_valid(valid32), .bus_ready(ready),
        .bus_we(we32), .bus_addr(addr32), .bus_be(be32), .bus_wdata(wdata32),
        .bus_rvalid(rvalid), .bus_rdata(rdata[31:0]), .bus_err(berr)
    );

    load_store_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(4)) dut64 (
        .clk(clk), .reset(reset), .lsu_req(req && sel), .lsu_we(we), .lsu_funct3(f3),
        .lsu_addr(addr), .lsu_wdata(wdata), .lsu_busy(busy64), .lsu_done(done64),
        .lsu_rdata(rdata64), .lsu_err(err64), .bus_valid(valid64), .bus_ready(ready),
        .bus_we(we64), .bus_addr(addr64), .bus_be(be64), .bus_wdata(wdata64),
        .bus_rvalid(rvalid), .bus_rdata(rdata), .bus_err(berr)
    );

    always_comb begin
        o_busy  = sel ? busy64  : busy32;
        o_done  = sel ? done64  : done32;
        o_err   = sel ? err64   : err32;
        o_valid = sel ? valid64 : valid32;
        o_we    = sel ? we64    : we32;
        o_rdata = sel ? rdata64 : {32'h0, rdata32};
        o_wdata = sel ? wdata64 : {32'h0, wdata32};
        o_addr  = sel ? addr64  : addr32;
        o_be    = sel ? be64    : {4'h0, be32};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic s, logic w, logic [2:0] f, logic [31:0] a,
                                logic [63:0] wd, logic [63:0] rd, int dly, logic be_rr,
                                logic b, logic [7:0] ebe, logic [63:0] ewd,
                                logic [63:0] erd, logic eerr);
        vec_t v;
        v.sel = s; v.we = w; v.f3 = f; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.rdly = dly; v.berr = be_rr; v.bus = b; v.be = ebe; v.bwdata = ewd;
        v.exp_rdata = erd; v.exp_err = eerr;
        return v;
    endfunction

    // Scoreboard consumer: every completion pops the oldest expected result.
    always @(posedge clk) begin
        #1;
        if (o_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done: got done with empty scoreboard");
            end else begin
                mon_e = sb.pop_front();
                chk("lsu_rdata", o_rdata, mon_e.rdata);
                chk("lsu_err", {63'h0, o_err}, {63'h0, mon_e.err});
            end
        end
    end

    // Runs one operation starting at a negedge; returns at the negedge of its done cycle.
    task automatic run(input vec_t v);
        exp_t e;
        logic [31:0] exp_addr;
        exp_addr = v.addr & (v.sel ? ~32'h7 : ~32'h3);
        sel = v.sel; req = 1'b1; we = v.we; f3 = v.f3; addr = v.addr; wdata = v.wdata;
        e.rdata = v.exp_rdata; e.err = v.exp_err;
        sb.push_back(e);
        @(negedge clk);
        req = 1'b0;
        if (!v.bus) begin
            chk("no_bus_valid", {63'h0, o_valid}, 64'h0);
        end else begin
            for (int k = 0; k <= v.rdly; k++) begin
                chk("req_valid", {63'h0, o_valid}, 64'h1);
                chk("req_busy", {63'h0, o_busy}, 64'h1);
                chk("bus_we", {63'h0, o_we}, {63'h0, v.we});
                chk("bus_addr", {32'h0, o_addr}, {32'h0, exp_addr});
                chk("bus_be", {56'h0, o_be}, {56'h0, v.be});
                chk("bus_wdata", o_wdata, v.bwdata);
                if (k == v.rdly) begin
                    ready = 1'b1;
                    berr  = v.we ? v.berr : 1'b0;
                end
                @(negedge clk);
            end
            ready = 1'b0; berr = 1'b0;
            if (!v.we) begin
                chk("resp_valid_low", {63'h0, o_valid}, 64'h0);
                rvalid = 1'b1; rdata = v.rdata; berr = v.berr;
                @(negedge clk);
                rvalid = 1'b0; berr = 1'b0;
            end
        end
        chk("done_latency", {63'h0, o_done}, 64'h1);
        chk("done_not_busy", {63'h0, o_busy}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        reset = 1'b1; req = 1'b0; we = 1'b0; sel = 1'b0; f3 = 3'd0; addr = '0;
        wdata = '0; rdata = '0; ready = 1'b0; rvalid = 1'b0; berr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl32", {59'h0, busy32, done32, err32, valid32, we32}, 64'h0);
        chk("rst_bus32", {be32, addr32, wdata32[27:0]}, 64'h0);
        chk("rst_rdata32", {32'h0, rdata32}, 64'h0);
        chk("rst_ctrl64", {59'h0, busy64, done64, err64, valid64, we64}, 64'h0);
        chk("rst_rdata64", rdata64, 64'h0);
        reset = 1'b0;
        @(negedge clk);

        //        sel we f3    addr          wdata                  rdata                  dly berr bus be     bwdata                 exp_rdata              err
        tbl.push_back(mk(0, 0, 3'b000, 32'h103, 64'h0, 64'h80FF_0000, 0, 0, 1, 8'h08, 64'h0, 64'hFFFF_FF80, 0));
        tbl.push_back(mk(0, 1, 3'b001, 32'h202, 64'h0000_ABCD, 64'h0, 3, 0, 1, 8'h0C, 64'hABCD_0000, 64'hFFFF_FF80, 0));
        tbl.push_back(mk(0, 0, 3'b010, 32'h101, 64'h0, 64'h0, 0, 0, 0, 8'h00, 64'h0, 64'hFFFF_FF80, 1));
        tbl.push_back(mk(0, 0, 3'b101, 32'h102, 64'h0, 64'h8001_1234, 0, 0, 1, 8'h0C, 64'h0, 64'h0000_8001, 0));
        tbl.push_back(mk(0, 0, 3'b001, 32'h100, 64'h0, 64'h1234_8001, 1, 0, 1, 8'h03, 64'h0, 64'hFFFF_8001, 0));
        tbl.push_back(mk(0, 0, 3'b010, 32'h104, 64'h0, 64'hDEAD_BEEF, 0, 0, 1, 8'h0F, 64'h0, 64'hDEAD_BEEF, 0));
        tbl.push_back(mk(0, 1, 3'b000, 32'h301, 64'h1234_56A5, 64'h0, 0, 0, 1, 8'h02, 64'h0000_A500, 64'hDEAD_BEEF, 0));
        tbl.push_back(mk(0, 1, 3'b010, 32'h300, 64'hCAFE_F00D, 64'h0, 0, 1, 1, 8'h0F, 64'hCAFE_F00D, 64'hDEAD_BEEF, 1));
        tbl.push_back(mk(0, 0, 3'b100, 32'h002, 64'h0, 64'h00AB_0000, 0, 1, 1, 8'h04, 64'h0, 64'hDEAD_BEEF, 1));
        tbl.push_back(mk(0, 0, 3'b011, 32'h000, 64'h0, 64'h0, 0, 0, 0, 8'h00, 64'h0, 64'hDEAD_BEEF, 1));
        tbl.push_back(mk(0, 1, 3'b001, 32'h203, 64'h0, 64'h0, 0, 0, 0, 8'h00, 64'h0, 64'hDEAD_BEEF, 1));
        tbl.push_back(mk(0, 0, 3'b000, 32'h001, 64'h0, 64'h0000_7F00, 0, 0, 1, 8'h02, 64'h0, 64'h0000_007F, 0));
        tbl.push_back(mk(1, 0, 3'b110, 32'h1004, 64'h0, 64'h8765_4321_0000_0000, 0, 0, 1, 8'hF0, 64'h0, 64'h0000_0000_8765_4321, 0));
        tbl.push_back(mk(1, 1, 3'b011, 32'h1008, 64'h1122_3344_5566_7788, 64'h0, 0, 0, 1, 8'hFF, 64'h1122_3344_5566_7788, 64'h0000_0000_8765_4321, 0));
        tbl.push_back(mk(1, 0, 3'b011, 32'h1004, 64'h0, 64'h0, 0, 0, 0, 8'h00, 64'h0, 64'h0000_0000_8765_4321, 1));
        tbl.push_back(mk(1, 0, 3'b000, 32'h1007, 64'h0, 64'h7F00_0000_0000_0000, 0, 0, 1, 8'h80, 64'h0, 64'h0000_0000_0000_007F, 0));

        // Back-to-back: each request is driven during the previous DONE cycle.
        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i]);
        end
        @(negedge clk);

        // Load timeout in RESP, then a late rvalid in IDLE must be ignored.
        sel = 1'b0; req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h0;
        mon_e.rdata = 64'h7F; mon_e.err = 1'b1;
        sb.push_back(mon_e);
        @(negedge clk);
        req = 1'b0; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        n = 0;
        while (!o_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", 64'(n), 64'd3);
        @(negedge clk);
        rvalid = 1'b1; rdata = 64'hFFFF_FFFF;
        @(negedge clk);
        rvalid = 1'b0;
        chk("late_rvalid_done", {62'h0, o_done, o_busy}, 64'h0);
        chk("late_rvalid_rdata", o_rdata, 64'h7F);

        // Reset while waiting in RESP aborts without a done pulse.
        @(negedge clk);
        req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h10;
        @(negedge clk);
        req = 1'b0; ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("resp_busy", {62'h0, o_busy, o_valid}, 64'h2);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ctrl", {59'h0, busy32, done32, err32, valid32, we32}, 64'h0);
        chk("midrst_bus", {be32, addr32, wdata32[27:0]}, 64'h0);
        chk("midrst_rdata", {32'h0, rdata32}, 64'h0);
        reset = 1'b0;
        @(negedge clk);
        hv = mk(0, 0, 3'b100, 32'h0, 64'h0, 64'hFF, 0, 0, 1, 8'h01, 64'h0, 64'hFF, 0);
        run(hv);

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
